// File: rtl/lock_btn_conditioner.sv
// Button front-end for the lock: synchronises and debounces btn_0/btn_1,
// turns each clean press into a one-cycle bit token and flags overlapping
// presses with a one-cycle illegal pulse.
module lock_btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       btn_0,
  input  logic       btn_1,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       illegal,
  output logic [1:0] btn_level
);

  localparam int unsigned NB = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD0,
    HOLD1,
    CONFLICT
  } state_t;

  logic [NB-1:0] sync_s1;
  logic [NB-1:0] sync_s2;
  logic [NB-1:0] btn_level_d;
  logic [NB-1:0] rise_q;
  logic [NB-1:0] lvl_q;
  state_t        state;
  state_t        state_nx;
  logic          bit_valid_nx;
  logic          bit_value_nx;
  logic          illegal_nx;

  // Two-flop synchroniser for both raw buttons.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= {btn_1, btn_0};
      sync_s2 <= sync_s1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;

    // Level flips only after the synchronised input has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge btn_reset) begin
      if (!btn_reset) begin
        cnt          <= '0;
        btn_level[i] <= 1'b0;
      end else if (sync_s2[i] == btn_level[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt          <= '0;
        btn_level[i] <= ~btn_level[i];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Rise detect, registered together with the matching level snapshot so
  // the FSM always sees a consistent (rise, level) pair.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      btn_level_d <= '0;
      rise_q      <= '0;
      lvl_q       <= '0;
    end else begin
      btn_level_d <= btn_level;
      rise_q      <= btn_level & ~btn_level_d;
      lvl_q       <= btn_level;
    end
  end

  // Press FSM state and registered token/illegal outputs.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state     <= IDLE;
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_valid <= bit_valid_nx;
      bit_value <= bit_value_nx;
      illegal   <= illegal_nx;
    end
  end

  // Next state: a rise while both levels are high is an overlap; a rise of
  // the other button after the held one released is a fresh press.
  always_comb begin
    state_nx     = state;
    bit_valid_nx = 1'b0;
    bit_value_nx = bit_value;
    illegal_nx   = 1'b0;
    case (state)
      IDLE: begin
        if ((rise_q != 2'b00) && (lvl_q == 2'b11)) begin
          state_nx   = CONFLICT;
          illegal_nx = 1'b1;
        end else if (rise_q[0]) begin
          state_nx     = HOLD0;
          bit_valid_nx = 1'b1;
          bit_value_nx = 1'b0;
        end else if (rise_q[1]) begin
          state_nx     = HOLD1;
          bit_valid_nx = 1'b1;
          bit_value_nx = 1'b1;
        end
      end
      HOLD0: begin
        if (rise_q[1] && lvl_q[0]) begin
          state_nx   = CONFLICT;
          illegal_nx = 1'b1;
        end else if (rise_q[1]) begin
          state_nx     = HOLD1;
          bit_valid_nx = 1'b1;
          bit_value_nx = 1'b1;
        end else if (!lvl_q[0]) begin
          state_nx = IDLE;
        end
      end
      HOLD1: begin
        if (rise_q[0] && lvl_q[1]) begin
          state_nx   = CONFLICT;
          illegal_nx = 1'b1;
        end else if (rise_q[0]) begin
          state_nx     = HOLD0;
          bit_valid_nx = 1'b1;
          bit_value_nx = 1'b0;
        end else if (!lvl_q[1]) begin
          state_nx = IDLE;
        end
      end
      CONFLICT: begin
        if (lvl_q == 2'b00) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lock_btn_conditioner.sv
// Bench for lock_btn_conditioner: directed scenarios plus random button
// activity, checked by a scoreboard fed from a window-based reference model.
module tb_lock_btn_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       btn_reset;
  logic       btn_0;
  logic       btn_1;
  logic       bit_valid;
  logic       bit_value;
  logic       illegal;
  logic [1:0] btn_level;

  typedef struct {
    int e;
    bit ill;
    bit val;
  } ev_t;

  ev_t        exp_q[$];
  int         edge_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_tok = 0;
  int         n_tok1 = 0;
  int         n_ill = 0;
  int         last_tok_edge = -1;
  int         s_tok, s_tok1, s_ill;
  logic [1:0] m_lvl = 2'b00;
  bit         m_conf = 1'b0;
  bit         hold_val = 1'b0;
  logic [D+1:0] h0 = '0;
  logic [D+1:0] h1 = '0;

  lock_btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .btn_reset(btn_reset),
    .btn_0(btn_0),
    .btn_1(btn_1),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .illegal(illegal),
    .btn_level(btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_tok  = n_tok;
    s_tok1 = n_tok1;
    s_ill  = n_ill;
  endtask

  task automatic phase(input string nm, input int tok, input int tok1, input int ill);
    chk({nm, " tokens"}, n_tok - s_tok, tok);
    chk({nm, " tokens of value 1"}, n_tok1 - s_tok1, tok1);
    chk({nm, " illegal pulses"}, n_ill - s_ill, ill);
  endtask

  // Reference model: a debounced level follows the raw input once the raw
  // sample seen through the synchroniser has held the opposite value for D
  // consecutive cycles. Press rules are applied to the level pair: both down
  // is an overlap (one illegal until both released), otherwise a newly
  // pressed button yields a token two cycles later.
  always @(posedge clk) begin
    logic [1:0] nlvl;
    edge_cnt++;
    if (!btn_reset) begin
      h0     = '0;
      h1     = '0;
      m_lvl  = 2'b00;
      m_conf = 1'b0;
      exp_q.delete();
    end else begin
      h0   = {h0[D:0], btn_0};
      h1   = {h1[D:0], btn_1};
      nlvl = m_lvl;
      if (m_lvl[0] ? (h0[D+1:2] == '0) : (&h0[D+1:2])) nlvl[0] = ~m_lvl[0];
      if (m_lvl[1] ? (h1[D+1:2] == '0) : (&h1[D+1:2])) nlvl[1] = ~m_lvl[1];
      if (m_conf) begin
        if (nlvl == 2'b00) m_conf = 1'b0;
      end else if (nlvl == 2'b11) begin
        exp_q.push_back('{edge_cnt + 2, 1'b1, 1'b0});
        m_conf = 1'b1;
      end else if ((nlvl & ~m_lvl) != 2'b00) begin
        exp_q.push_back('{edge_cnt + 2, 1'b0, nlvl[1]});
      end
      m_lvl = nlvl;
    end
  end

  // Monitor: compare every presented pulse against the scoreboard queue.
  always @(negedge clk) begin
    ev_t ev;
    if (!btn_reset) begin
      hold_val = 1'b0;
    end else begin
      chk("btn_level", int'(btn_level), int'(m_lvl));
      chk("valid and illegal together", int'(bit_valid & illegal), 0);
      if (bit_valid || illegal) begin
        if (bit_valid) begin
          n_tok++;
          if (bit_value) n_tok1++;
          last_tok_edge = edge_cnt;
        end
        if (illegal) n_ill++;
        chk("pulse expected", exp_q.size() > 0 ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          chk("pulse edge", edge_cnt, ev.e);
          chk("pulse is illegal", int'(illegal), int'(ev.ill));
          if (!ev.ill) begin
            chk("token value", int'(bit_value), int'(ev.val));
            hold_val = ev.val;
          end
        end
      end else begin
        chk("bit_value hold", int'(bit_value), int'(hold_val));
        if (exp_q.size() > 0) begin
          chk("pulse overdue", exp_q[0].e <= edge_cnt ? 1 : 0, 0);
          if (exp_q[0].e <= edge_cnt) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    btn_reset = 1'b0;
    btn_0     = 1'b0;
    btn_1     = 1'b0;
    #1;
    chk("reset outputs", int'({bit_valid, bit_value, illegal, btn_level}), 0);
    #10;
    btn_reset = 1'b1;

    // Idle after reset: nothing may appear.
    snap();
    tick(20);
    phase("idle", 0, 0, 0);
    chk("idle level", int'(btn_level), 0);

    // Clean btn_1 press.
    snap();
    btn_1 = 1'b1;
    k = edge_cnt + 1;
    tick(10);
    chk("btn_1 held level", int'(btn_level), 2);
    chk("btn_1 token latency", last_tok_edge, k + 7);
    btn_1 = 1'b0;
    tick(12);
    phase("clean btn_1", 1, 1, 0);

    // Bouncing btn_0 then stable.
    snap();
    for (int i = 0; i < 6; i++) begin
      btn_0 = ~btn_0;
      tick(2);
    end
    chk("bounce no token", n_tok - s_tok, 0);
    btn_0 = 1'b1;
    k = edge_cnt + 1;
    tick(12);
    chk("bounce token latency", last_tok_edge, k + 7);
    btn_0 = 1'b0;
    tick(12);
    phase("bounce", 1, 0, 0);

    // Overlap while btn_1 held, then re-press of btn_1 after full release.
    snap();
    btn_1 = 1'b1; tick(10);
    btn_0 = 1'b1; tick(8);
    btn_0 = 1'b0; tick(8);
    btn_0 = 1'b1; tick(8);
    btn_0 = 1'b0; tick(8);
    btn_1 = 1'b0; tick(8);
    btn_1 = 1'b1; tick(10);
    btn_1 = 1'b0; tick(10);
    phase("overlap", 2, 2, 1);

    // Simultaneous press.
    snap();
    btn_0 = 1'b1;
    btn_1 = 1'b1;
    tick(10);
    btn_0 = 1'b0;
    btn_1 = 1'b0;
    tick(10);
    phase("simultaneous", 0, 0, 1);

    // Reset in the middle of a debounce.
    snap();
    btn_0 = 1'b1;
    tick(2);
    btn_reset = 1'b0;
    #1;
    chk("mid reset outputs", int'({bit_valid, bit_value, illegal, btn_level}), 0);
    tick(2);
    btn_reset = 1'b1;
    k = edge_cnt + 1;
    tick(12);
    chk("post reset token latency", last_tok_edge, k + 7);
    btn_0 = 1'b0;
    tick(12);
    phase("mid reset", 1, 0, 0);

    // Random presses, glitches around the debounce length and resets.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 59) == 0) begin
        btn_reset = 1'b0;
        tick(int'($urandom_range(1, 3)));
        btn_reset = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) btn_0 = ~btn_0;
      if ($urandom_range(0, 2) == 0) btn_1 = ~btn_1;
      tick(int'($urandom_range(1, 8)));
    end
    btn_0 = 1'b0;
    btn_1 = 1'b0;
    tick(15);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_btn_conditioner.md
Name: lock_btn_conditioner

Overview:
- Upstream front-end of the lock datapath. Takes the raw btn_0/btn_1 push-button levels and synchronises and debounces them.
- Converts each clean press into a single-cycle bit token (bit_valid, bit_value) for the lock sequence FSM.
- Flags overlapping presses of the two buttons as a single-cycle illegal pulse. The downstream FSM uses this pulse to discard the partial code.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised input must differ from the debounced level before the level flips. Legal range 1..65535.
- CNT_W, 16, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- btn_reset  input  1  asynchronous, active-low reset.
- btn_0  input  1  raw button '0', asynchronous to clk, may bounce.
- btn_1  input  1  raw button '1', asynchronous to clk, may bounce.
- bit_valid  output  1  one-cycle pulse: a legal press was accepted.
- bit_value  output  1  value of the accepted press (0 = btn_0, 1 = btn_1). Meaningful only when bit_valid=1. Holds its last value otherwise.
- illegal  output  1  one-cycle pulse on detection of an overlapping press.
- btn_level  output  2  debounced levels: [1] = btn_1, [0] = btn_0.

Behaviour:
- Reset (btn_reset=0, asynchronous): all sync flops, counters and btn_level = 0; bit_valid = bit_value = illegal = 0; FSM = IDLE. Reset dominates everything, including mid-debounce and mid-press.
- Synchroniser: two flops per button (s1, s2), both reset to 0.
- Debounce, per button, independent of the other:
  - If s2 == btn_level[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and s2 still differs, btn_level[i] toggles on that edge and the counter clears.
  - Any single-cycle return of s2 to the current level clears the counter, so glitches shorter than DEBOUNCE_CYCLES cycles never propagate.
- Edge detect: rise[i] = btn_level[i] & ~btn_level_d[i], where btn_level_d is btn_level registered one cycle.
- Latency: a raw level change that stays stable from clock edge k produces
  - btn_level change at edge k+DEBOUNCE_CYCLES+1;
  - registered bit_valid/illegal high in the cycle after edge k+DEBOUNCE_CYCLES+3. Total latency is DEBOUNCE_CYCLES+3 edges.
- FSM states: IDLE, HOLD0, HOLD1, CONFLICT.
  - IDLE, rise[0] & ~btn_level[1]: go to HOLD0; pulse bit_valid with bit_value=0.
  - IDLE, rise[1] & ~btn_level[0]: go to HOLD1; pulse bit_valid with bit_value=1.
  - IDLE, rise[0] & rise[1] in the same cycle: go to CONFLICT; pulse illegal; no token.
  - HOLD0, btn_level[1] rises: go to CONFLICT; pulse illegal.
  - HOLD0, btn_level[0] falls with btn_level[1]=0: go to IDLE.
  - HOLD1 is symmetric to HOLD0.
  - CONFLICT: stay until btn_level == 2'b00, then go to IDLE. Further rises while in CONFLICT produce no token and no additional illegal pulse.
  - HOLD0 or HOLD1, release of the held button and rise of the other in the same cycle: treat as a release followed by a new press. Go to HOLD of the new button and emit its token; no illegal.
- Outputs are registered. bit_valid and illegal are never high in the same cycle. Each press produces at most one bit_valid.
- No backpressure: the downstream FSM must accept a token every cycle.

Test Plan (bench overrides DEBOUNCE_CYCLES=4):
- Reset then idle: btn_reset low 10 ns, then high -> all outputs 0, btn_level=00, no pulses for 20 cycles.
- Clean btn_1 press, held 10 cycles, then released -> exactly one bit_valid with bit_value=1, 7 edges after the press; btn_level[1] high during the hold; FSM returns to IDLE on release.
- Bounce: btn_0 toggled every 2 cycles for 12 cycles, then held high -> no pulse during toggling; one bit_valid with bit_value=0, 7 edges after the final stable rise.
- Overlap: btn_1 held, btn_0 pressed twice, then btn_1 released and pressed again -> one bit_valid(1) and a single illegal; the second btn_0 press produces nothing; after both buttons are released, the btn_1 re-press produces bit_valid(1).
- Simultaneous press: btn_0 and btn_1 rise on the same edge -> one illegal pulse, no bit_valid; no further pulses until both are released.
- Mid-debounce reset: btn_0 high 2 cycles, then btn_reset pulsed low -> counter and sync flops clear; after btn_reset returns high with btn_0 still high, bit_valid(0) appears 7 edges later.
